// File: rtl/alu_issue_ctrl.sv
// Issue/sequencing controller wrapped around a combinational ALU: IDLE -> EXEC -> OUT.
// Optional performance counters are built only when ALU_PERF_CNT_EN is defined.
module alu_issue_ctrl #(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_opcode,
    input  logic [6:0]  in_rd,
    input  logic [31:0] in_rs,
    input  logic [31:0] in_rsi,
    input  logic [31:0] in_rt,
    output logic [4:0]  alu_opcode,
    output logic [6:0]  alu_rd,
    output logic [31:0] alu_rs,
    output logic [31:0] alu_rsi,
    output logic [31:0] alu_rt,
    input  logic [6:0]  alu_rd_out,
    input  logic [6:0]  alu_branch,
    input  logic [4:0]  alu_op_out,
    input  logic [31:0] alu_result,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [6:0]  wb_rd,
    output logic [4:0]  wb_opcode,
    output logic [31:0] wb_result,
    output logic        br_taken,
    output logic [6:0]  br_target,
    output logic        div_zero,
    output logic        illegal,
    output logic [31:0] perf_ops,
    output logic [31:0] perf_stall
);

    localparam logic [4:0] OP_NOP = 5'd0;
    localparam logic [4:0] OP_MLT = 5'd2;
    localparam logic [4:0] OP_DIV = 5'd3;
    localparam logic [4:0] OP_B   = 5'd7;
    localparam logic [4:0] OP_BEG = 5'd8;
    localparam logic [4:0] OP_MAX = 5'd10;

    typedef enum logic [1:0] {IDLE, EXEC, OUT} state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic       accept;
    logic       op_nop;
    logic       op_ill;
    logic       exec_last;

    // Remaining EXEC cycles after the first one; single-cycle ops finish immediately.
    function automatic logic [3:0] first_cnt(input logic [4:0] op);
        case (op)
            OP_MLT:  return 4'(MUL_LAT - 1);
            OP_DIV:  return 4'(DIV_LAT - 1);
            default: return 4'd0;
        endcase
    endfunction

    assign in_ready  = (state == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign op_nop    = (in_opcode == OP_NOP);
    assign op_ill    = (in_opcode > OP_MAX);
    assign exec_last = (state == EXEC) && (cnt == 4'd0);
    assign wb_valid  = (state == OUT);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && !op_nop && !op_ill) state_nxt = EXEC;
            EXEC: if (cnt == 4'd0)
                      state_nxt = (alu_opcode == OP_B || alu_opcode == OP_BEG) ? IDLE : OUT;
            OUT:  if (wb_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            alu_opcode <= '0;
            alu_rd     <= '0;
            alu_rs     <= '0;
            alu_rsi    <= '0;
            alu_rt     <= '0;
            wb_rd      <= '0;
            wb_opcode  <= '0;
            wb_result  <= '0;
            br_taken   <= 1'b0;
            br_target  <= '0;
            div_zero   <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            state     <= state_nxt;
            br_taken  <= 1'b0;
            br_target <= '0;
            div_zero  <= 1'b0;
            illegal   <= 1'b0;

            if (accept) begin
                if (op_ill) begin
                    illegal <= 1'b1;
                end else if (!op_nop) begin
                    alu_opcode <= in_opcode;
                    alu_rd     <= in_rd;
                    alu_rs     <= in_rs;
                    alu_rsi    <= in_rsi;
                    alu_rt     <= in_rt;
                    cnt        <= first_cnt(in_opcode);
                end
            end

            if (state == EXEC && cnt != 4'd0) cnt <= cnt - 4'd1;

            // Operands are still stable here, so the ALU outputs reflect the held op.
            if (exec_last) begin
                case (alu_opcode)
                    OP_B: begin
                        br_taken  <= 1'b1;
                        br_target <= alu_branch;
                    end
                    OP_BEG: begin
                        if (alu_result[0]) begin
                            br_taken  <= 1'b1;
                            br_target <= alu_branch;
                        end
                    end
                    default: begin
                        wb_rd     <= alu_rd_out;
                        wb_opcode <= alu_op_out;
                        if (alu_opcode == OP_DIV && alu_rt == 32'd0) begin
                            wb_result <= 32'hFFFF_FFFF;
                            div_zero  <= 1'b1;
                        end else begin
                            wb_result <= alu_result;
                        end
                    end
                endcase
            end
        end
    end

`ifdef ALU_PERF_CNT_EN
    logic [1:0] stall_inc;

    // A back-pressured OUT cycle and a refused offer can coincide; both are counted.
    assign stall_inc = {1'b0, in_valid && !in_ready} + {1'b0, (state == OUT) && !wb_ready};

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ops   <= '0;
            perf_stall <= '0;
        end else begin
            if (accept && !op_nop && !op_ill) perf_ops <= perf_ops + 32'd1;
            perf_stall <= perf_stall + 32'(stall_inc);
        end
    end
`else
    assign perf_ops   = '0;
    assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: vector table plus hand-written back-pressure and reset sequences.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_opcode;
    logic [6:0]  in_rd;
    logic [31:0] in_rs, in_rsi, in_rt;
    logic [4:0]  alu_opcode;
    logic [6:0]  alu_rd;
    logic [31:0] alu_rs, alu_rsi, alu_rt;
    logic [6:0]  alu_rd_out, alu_branch;
    logic [4:0]  alu_op_out;
    logic [31:0] alu_result;
    logic        wb_valid, wb_ready;
    logic [6:0]  wb_rd;
    logic [4:0]  wb_opcode;
    logic [31:0] wb_result;
    logic        br_taken;
    logic [6:0]  br_target;
    logic        div_zero, illegal;
    logic [31:0] perf_ops, perf_stall;

    int n_cmp = 0;
    int n_err = 0;

    alu_issue_ctrl #(.MUL_LAT(2), .DIV_LAT(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_rd(in_rd),
        .in_rs(in_rs), .in_rsi(in_rsi), .in_rt(in_rt),
        .alu_opcode(alu_opcode), .alu_rd(alu_rd), .alu_rs(alu_rs), .alu_rsi(alu_rsi), .alu_rt(alu_rt),
        .alu_rd_out(alu_rd_out), .alu_branch(alu_branch), .alu_op_out(alu_op_out),
        .alu_result(alu_result),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_opcode(wb_opcode),
        .wb_result(wb_result),
        .br_taken(br_taken), .br_target(br_target), .div_zero(div_zero), .illegal(illegal),
        .perf_ops(perf_ops), .perf_stall(perf_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple combinational ALU standing in for the real one.
    always_comb begin
        alu_rd_out = alu_rd;
        alu_branch = alu_rd;
        alu_op_out = alu_opcode;
        alu_result = 32'd0;
        case (alu_opcode)
            5'd1:  alu_result = alu_rsi;
            5'd2:  alu_result = alu_rs * alu_rt;
            5'd3:  alu_result = (alu_rt != 32'd0) ? alu_rs / alu_rt : 32'd0;
            5'd4:  alu_result = alu_rs - alu_rt;
            5'd5:  alu_result = alu_rs + alu_rt;
            5'd6:  alu_result = alu_rs;
            5'd8:  alu_result = {31'd0, alu_rs == alu_rt};
            5'd9:  alu_result = alu_rs >> alu_rt[4:0];
            5'd10: alu_result = alu_rsi;
            default: alu_result = 32'd0;
        endcase
    end

    typedef struct {
        logic [4:0]  op;
        logic [6:0]  rd;
        logic [31:0] rs;
        logic [31:0] rsi;
        logic [31:0] rt;
        int          exp_wb;
        int          exp_br;
        int          exp_dz;
        int          exp_ill;
        int          exp_cyc;
        logic [31:0] exp_res;
        logic [6:0]  exp_tgt;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] op, input logic [6:0] rd,
                         input logic [31:0] rs, input logic [31:0] rsi, input logic [31:0] rt);
        in_valid  = 1'b1;
        in_opcode = op;
        in_rd     = rd;
        in_rs     = rs;
        in_rsi    = rsi;
        in_rt     = rt;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int wb_n = 0, br_n = 0, dz_n = 0, ill_n = 0;
        int wb_f = -1, br_f = -1, dz_f = -1, ill_f = -1;
        @(negedge clk);
        check($sformatf("v%0d in_ready_idle", idx), 32'(in_ready), 32'd1);
        drive(v.op, v.rd, v.rs, v.rsi, v.rt);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) in_valid = 1'b0;
            if (wb_valid) begin
                wb_n++;
                if (wb_f < 0) begin
                    wb_f = c;
                    check($sformatf("v%0d wb_rd", idx), 32'(wb_rd), 32'(v.rd));
                    check($sformatf("v%0d wb_opcode", idx), 32'(wb_opcode), 32'(v.op));
                    check($sformatf("v%0d wb_result", idx), wb_result, v.exp_res);
                end
            end
            if (br_taken) begin
                br_n++;
                if (br_f < 0) begin
                    br_f = c;
                    check($sformatf("v%0d br_target", idx), 32'(br_target), 32'(v.exp_tgt));
                end
            end
            if (div_zero) begin dz_n++;  if (dz_f < 0)  dz_f  = c; end
            if (illegal)  begin ill_n++; if (ill_f < 0) ill_f = c; end
        end
        check($sformatf("v%0d wb_valid_cycles", idx), 32'(wb_n), 32'(v.exp_wb));
        check($sformatf("v%0d br_taken_cycles", idx), 32'(br_n), 32'(v.exp_br));
        check($sformatf("v%0d div_zero_cycles", idx), 32'(dz_n), 32'(v.exp_dz));
        check($sformatf("v%0d illegal_cycles", idx), 32'(ill_n), 32'(v.exp_ill));
        if (v.exp_wb != 0)  check($sformatf("v%0d wb_latency", idx), 32'(wb_f), 32'(v.exp_cyc));
        if (v.exp_br != 0)  check($sformatf("v%0d br_latency", idx), 32'(br_f), 32'(v.exp_cyc));
        if (v.exp_dz != 0)  check($sformatf("v%0d dz_latency", idx), 32'(dz_f), 32'(v.exp_cyc));
        if (v.exp_ill != 0) check($sformatf("v%0d ill_latency", idx), 32'(ill_f), 32'(v.exp_cyc));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits;
        //            op     rd      rs      rsi           rt     wb br dz il cyc res            tgt
        vecs[0]  = '{5'd5,  7'd3,   32'd5,  32'd0,        32'd7, 1, 0, 0, 0, 2, 32'd12,        7'h00};
        vecs[1]  = '{5'd2,  7'd4,   32'd6,  32'd0,        32'd7, 1, 0, 0, 0, 3, 32'd42,        7'h00};
        vecs[2]  = '{5'd3,  7'd5,   32'd9,  32'd0,        32'd0, 1, 0, 1, 0, 9, 32'hFFFF_FFFF, 7'h00};
        vecs[3]  = '{5'd3,  7'd6,   32'd9,  32'd0,        32'd3, 1, 0, 0, 0, 9, 32'd3,         7'h00};
        vecs[4]  = '{5'd7,  7'h15,  32'd0,  32'd0,        32'd0, 0, 1, 0, 0, 2, 32'd0,         7'h15};
        vecs[5]  = '{5'd8,  7'h22,  32'd1,  32'd0,        32'd2, 0, 0, 0, 0, 0, 32'd0,         7'h00};
        vecs[6]  = '{5'd8,  7'h0A,  32'd4,  32'd0,        32'd4, 0, 1, 0, 0, 2, 32'd0,         7'h0A};
        vecs[7]  = '{5'd12, 7'd1,   32'd1,  32'd0,        32'd1, 0, 0, 0, 1, 1, 32'd0,         7'h00};
        vecs[8]  = '{5'd0,  7'd9,   32'd1,  32'd0,        32'd1, 0, 0, 0, 0, 0, 32'd0,         7'h00};
        vecs[9]  = '{5'd4,  7'd1,   32'd10, 32'd0,        32'd3, 1, 0, 0, 0, 2, 32'd7,         7'h00};
        vecs[10] = '{5'd1,  7'd2,   32'd0,  32'h0000ABCD, 32'd0, 1, 0, 0, 0, 2, 32'h0000ABCD,  7'h00};
        vecs[11] = '{5'd31, 7'd2,   32'd0,  32'd0,        32'd0, 0, 0, 0, 1, 1, 32'd0,         7'h00};

        rst = 1'b1; in_valid = 1'b0; wb_ready = 1'b1;
        in_opcode = '0; in_rd = '0; in_rs = '0; in_rsi = '0; in_rt = '0;
        repeat (3) @(negedge clk);
        check("rst in_ready", 32'(in_ready), 32'd0);
        check("rst wb_valid", 32'(wb_valid), 32'd0);
        check("rst alu_opcode", 32'(alu_opcode), 32'd0);
        check("rst wb_result", wb_result, 32'd0);
        check("rst br_taken", 32'(br_taken), 32'd0);
        check("rst perf_ops", perf_ops, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // NOP keeps the controller in IDLE.
        @(negedge clk);
        drive(5'd0, 7'd0, 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        check("nop in_ready", 32'(in_ready), 32'd1);

        // MLT 6*7 with writeback stalled for three OUT cycles.
        wb_ready = 1'b0;
        drive(5'd2, 7'd8, 32'd6, 32'd0, 32'd7);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp exec in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("bp early wb_valid", 32'(wb_valid), 32'd0);
        for (int c = 3; c <= 5; c++) begin
            @(negedge clk);
            check($sformatf("bp c%0d wb_valid", c), 32'(wb_valid), 32'd1);
            check($sformatf("bp c%0d wb_result", c), wb_result, 32'd42);
            check($sformatf("bp c%0d in_ready", c), 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        check("bp c6 wb_valid", 32'(wb_valid), 32'd1);
        wb_ready = 1'b1;
        @(negedge clk);
        check("bp done wb_valid", 32'(wb_valid), 32'd0);
        check("bp done in_ready", 32'(in_ready), 32'd1);

        // Reset in the middle of a DIV by zero aborts it silently.
        drive(5'd3, 7'd5, 32'd9, 32'd0, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check("abort rst in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("abort alu_opcode", 32'(alu_opcode), 32'd0);
        hits = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (wb_valid || div_zero || br_taken) hits++;
        end
        check("abort no output", 32'(hits), 32'd0);
        check("abort in_ready", 32'(in_ready), 32'd1);
        check("abort perf_ops", perf_ops, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
